frame_update_scheduler: RTL

//  Sequences once-per-frame game-logic updates (paddle, ball, score, ...) during vertical blanking.

---
 rtl/pong_video_pkg.sv | 15 +
 rtl/sched_timeout_counter.sv | 34 +++
 rtl/frame_update_scheduler.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/pong_video_pkg.sv
// Video timing constants shared with the video timer, plus the update-scheduler state type.
package pong_video_pkg;

    localparam int H_ACTIVE = 640;
    localparam int H_TOTAL  = 800;
    localparam int V_ACTIVE = 480;
    localparam int V_TOTAL  = 521;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2
    } sched_state_t;

endpackage

// File: rtl/sched_timeout_counter.sv
// Per-client watchdog: counts cycles while enabled; expired flags the edge on which
// the count reaches TIMEOUT_CYC.
module sched_timeout_counter #(
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic clk25,
    input  logic Reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] LAST_C = CW'(TIMEOUT_CYC - 1);
    localparam logic [CW-1:0] MAX_C  = CW'(TIMEOUT_CYC);

    logic [CW-1:0] count_r;

    // Saturating cycle counter, cleared while a client is being started
    always_ff @(posedge clk25 or posedge Reset) begin
        if (Reset) begin
            count_r <= '0;
        end else if (clear) begin
            count_r <= '0;
        end else if (enable && (count_r != MAX_C)) begin
            count_r <= count_r + CW'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign expired = enable && (count_r == LAST_C);

endmodule

// File: rtl/frame_update_scheduler.sv
// Issues ordered once-per-frame start strobes to N_CLIENTS update units during vblank.
// Optional build macro FRAME_SKIP_EN: sequences run on the first and then every (SKIP_N+1)th qualifying frame.
module frame_update_scheduler
    import pong_video_pkg::*;
#(
    parameter int N_CLIENTS   = 3,
    parameter int V_ACTIVE    = pong_video_pkg::V_ACTIVE,
    parameter int H_TOTAL     = pong_video_pkg::H_TOTAL,
    parameter int V_TOTAL     = pong_video_pkg::V_TOTAL,
    parameter int TIMEOUT_CYC = 4096,
    parameter int SKIP_N      = 1
) (
    input  logic                 clk25,
    input  logic                 Reset,
    input  logic                 enable,
    input  logic [9:0]           xpos,
    input  logic [9:0]           ypos,
    input  logic [N_CLIENTS-1:0] client_done,
    input  logic                 clr_flags,
    output logic [N_CLIENTS-1:0] client_start,
    output logic                 frame_tick,
    output logic                 busy,
    output logic                 overrun,
    output logic [N_CLIENTS-1:0] timeout_flags,
    output logic [15:0]          frame_count
);

    localparam int IDX_W = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;
    localparam logic [9:0]           H_LAST_C   = 10'(H_TOTAL - 1);
    localparam logic [9:0]           V_LAST_C   = 10'(V_TOTAL - 1);
    localparam logic [9:0]           V_TRIG_C   = 10'(V_ACTIVE);
    localparam logic [IDX_W-1:0]     IDX_LAST_C = IDX_W'(N_CLIENTS - 1);
    localparam logic [N_CLIENTS-1:0] ONE_C      = N_CLIENTS'(1);
    localparam logic [1:0]           ST_IDLE    = IDLE;
    localparam logic [1:0]           ST_START   = START;
    localparam logic [1:0]           ST_WAIT    = WAIT;

    logic [1:0]           state_r;
    logic [IDX_W-1:0]     idx_r;
    logic [N_CLIENTS-1:0] client_start_r;
    logic                 frame_tick_r;
    logic                 busy_r;
    logic                 overrun_r;
    logic [N_CLIENTS-1:0] timeout_flags_r;
    logic [15:0]          frame_count_r;

    logic                 trig_pos_s;
    logic                 wrap_s;
    logic                 gate_s;
    logic                 trigger_s;
    logic                 abort_s;
    logic                 done_s;
    logic                 expired_s;
    logic                 advance_s;
    logic [N_CLIENTS-1:0] flag_set_s;

    assign trig_pos_s = enable && (xpos == 10'd0) && (ypos == V_TRIG_C);
    assign wrap_s     = (xpos == H_LAST_C) && (ypos == V_LAST_C);
    assign abort_s    = (state_r != ST_IDLE) && wrap_s;
    assign done_s     = client_done[idx_r];
    assign advance_s  = (state_r == ST_WAIT) && !wrap_s && (done_s || expired_s);
    assign trigger_s  = (state_r == ST_IDLE) && trig_pos_s && gate_s;

`ifdef FRAME_SKIP_EN
    localparam int SW = (SKIP_N > 0) ? $clog2(SKIP_N + 1) : 1;
    logic [SW-1:0] skip_r;

    // Counts qualifying frames down to zero; zero means the next one fires
    always_ff @(posedge clk25 or posedge Reset) begin
        if (Reset) begin
            skip_r <= '0;
        end else if ((state_r == ST_IDLE) && trig_pos_s) begin
            skip_r <= (skip_r == '0) ? SW'(SKIP_N) : (skip_r - SW'(1));
        end else begin
            skip_r <= skip_r;
        end
    end

    assign gate_s = (skip_r == '0);
`else
    assign gate_s = 1'b1;
`endif

    sched_timeout_counter #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .clk25   (clk25),
        .Reset   (Reset),
        .clear   (state_r != ST_WAIT),
        .enable  (state_r == ST_WAIT),
        .expired (expired_s)
    );

    // A timeout is only recorded when the client did not answer on that same edge
    always_comb begin
        flag_set_s = '0;
        if (advance_s && !done_s) begin
            flag_set_s = ONE_C << idx_r;
        end else begin
            flag_set_s = '0;
        end
    end

    // Sequencer: strobe, wait for done/timeout, move to next client; frame wrap aborts
    always_ff @(posedge clk25 or posedge Reset) begin
        if (Reset) begin
            state_r        <= ST_IDLE;
            idx_r          <= '0;
            client_start_r <= '0;
            frame_tick_r   <= 1'b0;
            busy_r         <= 1'b0;
            frame_count_r  <= 16'd0;
        end else begin
            client_start_r <= '0;
            frame_tick_r   <= 1'b0;
            if (abort_s) begin
                state_r <= ST_IDLE;
                busy_r  <= 1'b0;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (trigger_s) begin
                            state_r        <= ST_START;
                            idx_r          <= '0;
                            client_start_r <= ONE_C;
                            frame_tick_r   <= 1'b1;
                            busy_r         <= 1'b1;
                            frame_count_r  <= frame_count_r + 16'd1;
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end
                    ST_START: begin
                        state_r <= ST_WAIT;
                    end
                    ST_WAIT: begin
                        if (advance_s && (idx_r == IDX_LAST_C)) begin
                            state_r <= ST_IDLE;
                            busy_r  <= 1'b0;
                        end else if (advance_s) begin
                            state_r        <= ST_START;
                            idx_r          <= idx_r + IDX_W'(1);
                            client_start_r <= ONE_C << (idx_r + IDX_W'(1));
                        end else begin
                            state_r <= ST_WAIT;
                        end
                    end
                    default: begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Sticky status: a set on the same edge as clr_flags wins
    always_ff @(posedge clk25 or posedge Reset) begin
        if (Reset) begin
            overrun_r       <= 1'b0;
            timeout_flags_r <= '0;
        end else begin
            overrun_r       <= (overrun_r & ~clr_flags) | abort_s;
            timeout_flags_r <= (clr_flags ? '0 : timeout_flags_r) | flag_set_s;
        end
    end

    assign client_start  = client_start_r;
    assign frame_tick    = frame_tick_r;
    assign busy          = busy_r;
    assign overrun       = overrun_r;
    assign timeout_flags = timeout_flags_r;
    assign frame_count   = frame_count_r;

endmodule
